// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between the fetch and data ports.
// Define MEM_PORT_ARBITER_LOCK_EN to add d_lock, which holds off fetch during atomic data sequences.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
`ifdef MEM_PORT_ARBITER_LOCK_EN
    input  logic                d_lock,
`endif
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic              TAG_FETCH = 1'b0;
    localparam logic              TAG_DATA  = 1'b1;

    logic [3:0]        starve_cnt;
    logic              fetch_forced;
    logic              lock_q;
    logic              issue_rd;
    logic [RD_LAT-1:0] tag_vld;
    logic [RD_LAT-1:0] tag_id;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    assign fetch_forced = (starve_cnt == 4'(STARVE_MAX));

    // Grants are forced low while reset is asserted so every output reads 0 immediately.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (rst_n) begin
            if (i_req && !lock_q && (!d_req || fetch_forced)) begin
                i_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (i_gnt) begin
            mem_en   = 1'b1;
            mem_be   = '1;
            mem_addr = i_addr & WORD_MASK;
        end else if (d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_be    = d_we ? d_be : '1;
            mem_addr  = d_addr & WORD_MASK;
            mem_wdata = d_wdata;
        end
    end

    assign issue_rd = i_gnt | (d_gnt & ~d_we);

    // Counts consecutive denied fetch cycles; sticks at STARVE_MAX until fetch wins or drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!i_req || i_gnt) begin
            starve_cnt <= '0;
        end else if (!fetch_forced) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

`ifdef MEM_PORT_ARBITER_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= 1'b0;
        end else if (d_gnt) begin
            lock_q <= d_lock;
        end
    end
`else
    assign lock_q = 1'b0;
`endif

    // Stage 0 holds the access issued last cycle; the last stage lines up with mem_rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
            tag_id  <= '0;
        end else begin
            tag_vld[0] <= issue_rd;
            tag_id[0]  <= d_gnt;
            for (int k = 1; k < RD_LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
            end
        end
    end

    assign i_rvalid = tag_vld[RD_LAT-1] && (tag_id[RD_LAT-1] == TAG_FETCH);
    assign d_rvalid = tag_vld[RD_LAT-1] && (tag_id[RD_LAT-1] == TAG_DATA);
    assign i_rdata  = i_rvalid ? mem_rdata : i_rdata_q;
    assign d_rdata  = d_rvalid ? mem_rdata : d_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            i_rdata_q <= i_rdata;
            d_rdata_q <= d_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: checks two arbiter instances (RD_LAT=1 and RD_LAT=3) against a transaction-level model.
// Both instances share stimulus; define MEM_PORT_ARBITER_LOCK_EN to include the d_lock scenario.
module tb_mem_port_arbiter;

    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
`ifdef MEM_PORT_ARBITER_LOCK_EN
    logic        d_lock;
`endif
    logic [31:0] mem_rdata;

    logic        i_gnt_w[2];
    logic        i_rvalid_w[2];
    logic [31:0] i_rdata_w[2];
    logic        d_gnt_w[2];
    logic        d_rvalid_w[2];
    logic [31:0] d_rdata_w[2];
    logic        mem_en_w[2];
    logic        mem_we_w[2];
    logic [3:0]  mem_be_w[2];
    logic [31:0] mem_addr_w[2];
    logic [31:0] mem_wdata_w[2];

    typedef struct {
        int issue;
        bit is_data;
    } iss_t;

    iss_t        iss[$];
    int          hd[2];
    int          denied;
    bit          lock_m;
    logic [31:0] held_i[2];
    logic [31:0] held_d[2];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    // RAM read data is a cycle stamp, so any latency error shows up as a data miscompare.
    assign mem_rdata = 32'hD00D_0000 ^ cyc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .STARVE_MAX(SM)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt_w[0]), .i_rvalid(i_rvalid_w[0]), .i_rdata(i_rdata_w[0]),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
`ifdef MEM_PORT_ARBITER_LOCK_EN
        .d_lock(d_lock),
`endif
        .d_gnt(d_gnt_w[0]), .d_rvalid(d_rvalid_w[0]), .d_rdata(d_rdata_w[0]),
        .mem_en(mem_en_w[0]), .mem_we(mem_we_w[0]), .mem_be(mem_be_w[0]), .mem_addr(mem_addr_w[0]),
        .mem_wdata(mem_wdata_w[0]), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3), .STARVE_MAX(SM)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt_w[1]), .i_rvalid(i_rvalid_w[1]), .i_rdata(i_rdata_w[1]),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
`ifdef MEM_PORT_ARBITER_LOCK_EN
        .d_lock(d_lock),
`endif
        .d_gnt(d_gnt_w[1]), .d_rvalid(d_rvalid_w[1]), .d_rdata(d_rdata_w[1]),
        .mem_en(mem_en_w[1]), .mem_we(mem_we_w[1]), .mem_be(mem_be_w[1]), .mem_addr(mem_addr_w[1]),
        .mem_wdata(mem_wdata_w[1]), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    // Model: grant from request/starvation/lock rules, reads remembered as (issue cycle, requester).
    task automatic checkOutput();
        bit   ig, dg, ev_i, ev_d;
        int   lat;
        iss_t e;
        if (!rst_n) begin
            for (int n = 0; n < 2; n++) begin
                chk("rst_i_gnt", i_gnt_w[n], 0);
                chk("rst_d_gnt", d_gnt_w[n], 0);
                chk("rst_mem_en", mem_en_w[n], 0);
                chk("rst_mem_we", mem_we_w[n], 0);
                chk("rst_i_rvalid", i_rvalid_w[n], 0);
                chk("rst_d_rvalid", d_rvalid_w[n], 0);
                chk("rst_i_rdata", i_rdata_w[n], 0);
                chk("rst_d_rdata", d_rdata_w[n], 0);
                held_i[n] = '0;
                held_d[n] = '0;
                hd[n]     = 0;
            end
            iss.delete();
            denied = 0;
            lock_m = 1'b0;
            return;
        end
        ig = i_req && !lock_m && (!d_req || denied >= SM);
        dg = d_req && !ig;
        for (int n = 0; n < 2; n++) begin
            lat = (n == 0) ? 1 : 3;
            chk("i_gnt", i_gnt_w[n], ig);
            chk("d_gnt", d_gnt_w[n], dg);
            chk("mem_en", mem_en_w[n], ig || dg);
            chk("mem_we", mem_we_w[n], dg && d_we);
            if (ig) begin
                chk("mem_addr_i", mem_addr_w[n], {i_addr[31:2], 2'b00});
                chk("mem_be_i", mem_be_w[n], 4'hF);
            end else if (dg) begin
                chk("mem_addr_d", mem_addr_w[n], {d_addr[31:2], 2'b00});
                chk("mem_be_d", mem_be_w[n], d_we ? d_be : 4'hF);
                if (d_we) chk("mem_wdata", mem_wdata_w[n], d_wdata);
            end
            ev_i = 1'b0;
            ev_d = 1'b0;
            if (hd[n] < iss.size() && iss[hd[n]].issue + lat == cyc) begin
                if (iss[hd[n]].is_data) begin
                    ev_d      = 1'b1;
                    held_d[n] = mem_rdata;
                end else begin
                    ev_i      = 1'b1;
                    held_i[n] = mem_rdata;
                end
                hd[n]++;
            end
            chk("i_rvalid", i_rvalid_w[n], ev_i);
            chk("d_rvalid", d_rvalid_w[n], ev_d);
            chk("i_rdata", i_rdata_w[n], held_i[n]);
            chk("d_rdata", d_rdata_w[n], held_d[n]);
        end
        if (ig || (dg && !d_we)) begin
            e.issue   = cyc;
            e.is_data = dg;
            iss.push_back(e);
        end
        if (i_req && !ig) denied++;
        else denied = 0;
`ifdef MEM_PORT_ARBITER_LOCK_EN
        if (dg) lock_m = d_lock;
`endif
    endtask

    always @(negedge clk) checkOutput();

    task automatic applyStimulus(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                                 input logic [3:0] be, input logic [31:0] da, input logic [31:0] wd,
                                 input bit lk);
        @(posedge clk);
        #1;
        i_req   = ir;
        i_addr  = ia;
        d_req   = dr;
        d_we    = dw;
        d_be    = be;
        d_addr  = da;
        d_wdata = wd;
`ifdef MEM_PORT_ARBITER_LOCK_EN
        d_lock  = lk;
`endif
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int ic, dc;
        rst_n   = 1'b0;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_be    = '0;
        d_addr  = '0;
        d_wdata = '0;
`ifdef MEM_PORT_ARBITER_LOCK_EN
        d_lock  = 1'b0;
`endif
        idle(2);
        #1;
        chk("init_mem_en", mem_en_w[0], 0);
        chk("init_i_rdata", i_rdata_w[0], 0);
        rst_n = 1'b1;
        idle(2);

        $display("[TB] fetch only");
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0);
        #1;
        chk("fo_i_gnt", i_gnt_w[0], 1);
        chk("fo_mem_en", mem_en_w[0], 1);
        chk("fo_mem_addr", mem_addr_w[0], 32'h100);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("fo_i_rvalid", i_rvalid_w[0], 1);
        chk("fo_i_rdata", i_rdata_w[0], mem_rdata);
        idle(3);

        $display("[TB] sub-word write");
        applyStimulus(0, 0, 1, 1, 4'b0001, 32'h203, 32'hCAFE_BABE, 0);
        #1;
        chk("wr_d_gnt", d_gnt_w[0], 1);
        chk("wr_mem_we", mem_we_w[0], 1);
        chk("wr_mem_be", mem_be_w[0], 4'b0001);
        chk("wr_mem_addr", mem_addr_w[0], 32'h200);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("wr_no_d_rvalid", d_rvalid_w[0], 0);
        idle(3);

        $display("[TB] contention");
        ic = 0;
        dc = 0;
        for (int k = 0; k < 15; k++) begin
            applyStimulus(1, 32'h1000 + 4 * ic, 1, 0, 4'hF, 32'h4000 + 4 * dc, 0, 0);
            #1;
            chk("ct_d_gnt", d_gnt_w[0], (k % 5) != 4);
            chk("ct_i_gnt", i_gnt_w[0], (k % 5) == 4);
            if (k % 5 == 4) ic++;
            else dc++;
        end
        idle(4);

        $display("[TB] alternating reads, RD_LAT=3");
        for (int k = 0; k < 10; k++) begin
            if (k < 6 && k % 2 == 0) applyStimulus(1, 32'h2000 + 4 * k, 0, 0, 0, 0, 0, 0);
            else if (k < 6) applyStimulus(0, 0, 1, 0, 4'hF, 32'h3000 + 4 * k, 0, 0);
            else applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            if (k >= 3) begin
                chk("alt_i_rvalid", i_rvalid_w[1], (k - 3 < 6) && ((k - 3) % 2 == 0));
                chk("alt_d_rvalid", d_rvalid_w[1], (k - 3 < 6) && ((k - 3) % 2 == 1));
                if (i_rvalid_w[1] || d_rvalid_w[1])
                    chk("alt_rdata", i_rvalid_w[1] ? i_rdata_w[1] : d_rdata_w[1], mem_rdata);
            end else begin
                chk("alt_early_rvalid", i_rvalid_w[1] | d_rvalid_w[1], 0);
            end
        end
        idle(2);

        $display("[TB] reset with reads in flight");
        applyStimulus(1, 32'h500, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 4'hF, 32'h600, 0, 0);
        applyStimulus(1, 32'h504, 1, 0, 4'hF, 32'h604, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        for (int n = 0; n < 2; n++) begin
            chk("mr_i_gnt", i_gnt_w[n], 0);
            chk("mr_d_gnt", d_gnt_w[n], 0);
            chk("mr_mem_en", mem_en_w[n], 0);
            chk("mr_mem_addr", mem_addr_w[n], 0);
            chk("mr_rvalid", i_rvalid_w[n] | d_rvalid_w[n], 0);
            chk("mr_i_rdata", i_rdata_w[n], 0);
            chk("mr_d_rdata", d_rdata_w[n], 0);
        end
        idle(2);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            chk("mr_post_rv1", i_rvalid_w[0] | d_rvalid_w[0], 0);
            chk("mr_post_rv3", i_rvalid_w[1] | d_rvalid_w[1], 0);
        end

`ifdef MEM_PORT_ARBITER_LOCK_EN
        $display("[TB] locked read-then-write");
        applyStimulus(1, 32'h700, 1, 0, 4'hF, 32'h800, 0, 1);
        #1;
        chk("lk_rd_d_gnt", d_gnt_w[0], 1);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1, 32'h700, 0, 0, 0, 0, 0, 0);
            #1;
            chk("lk_starved_i_gnt", i_gnt_w[0], 0);
        end
        applyStimulus(1, 32'h700, 1, 1, 4'b0011, 32'h800, 32'h1234_5678, 0);
        #1;
        chk("lk_wr_d_gnt", d_gnt_w[0], 1);
        chk("lk_wr_i_gnt", i_gnt_w[0], 0);
        applyStimulus(1, 32'h700, 0, 0, 0, 0, 0, 0);
        #1;
        chk("lk_release_i_gnt", i_gnt_w[0], 1);
`endif

        idle(6);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
